// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - Tuse/Tnew hazard controller with mult/div occupancy tracking
//
// Compares the D-stage instruction against E and M using a Tuse/Tnew model and
// tracks how long the multi-cycle mult/div unit stays busy.
// Optional feature macro: HAZ_PERF_CNT_EN (adds the stall_cnt performance counter).
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous active-low reset
//   IR_D       in  32   instruction in D
//   IR_E       in  32   instruction in E (ID/EX output)
//   IR_M       in  32   instruction in M
//   stall      out  1   hold PC and IF/ID
//   clear_E    out  1   ID/EX loads a nop on the next edge
//   md_start   out  1   mult/div unit starts this cycle
//   md_busy    out  1   mult/div unit occupied
//   stall_cnt  out 32   number of stalled cycles (HAZ_PERF_CNT_EN only)
module hazard_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] IR_D,
   input  logic [31:0] IR_E,
   input  logic [31:0] IR_M,
   output logic        stall,
   output logic        clear_E,
   output logic        md_start,
   output logic        md_busy
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] dst;       // 0 when the instruction writes no register
      logic       rd_rs;
      logic [1:0] tuse_rs;
      logic       rd_rt;
      logic [1:0] tuse_rt;
      logic [1:0] tnew_e;
      logic [1:0] tnew_m;
      logic       md_class;
      logic       md_op;     // mult/multu/div/divu
      logic       md_div;
   } dec_t;

   function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn,
                                   input logic [4:0] rs, input logic [4:0] rt,
                                   input logic [4:0] rd);
      dec_t d;
      logic r_alu, jr, mul, dv, mf, mt, lw, sw, br, jal, imm_wr;
      r_alu  = (op == 6'h00) && (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                                            6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b});
      jr     = (op == 6'h00) && (fn == 6'h08);
      mul    = (op == 6'h00) && (fn == 6'h18 || fn == 6'h19);
      dv     = (op == 6'h00) && (fn == 6'h1a || fn == 6'h1b);
      mf     = (op == 6'h00) && (fn == 6'h10 || fn == 6'h12);
      mt     = (op == 6'h00) && (fn == 6'h11 || fn == 6'h13);
      lw     = (op == 6'h23);
      sw     = (op == 6'h2b);
      br     = (op == 6'h04 || op == 6'h05);
      jal    = (op == 6'h03);
      imm_wr = (op == 6'h0d || op == 6'h0f || op == 6'h09);

      d.rs       = rs;
      d.rt       = rt;
      d.dst      = (r_alu || mf) ? rd : (lw || imm_wr) ? rt : jal ? 5'd31 : 5'd0;
      // lui is the only immediate writer that does not read rs
      d.rd_rs    = r_alu || jr || mul || dv || mt || lw || sw || br ||
                   (op == 6'h0d) || (op == 6'h09);
      d.tuse_rs  = (br || jr) ? 2'd0 : 2'd1;
      d.rd_rt    = r_alu || mul || dv || sw || br;
      d.tuse_rt  = br ? 2'd0 : sw ? 2'd2 : 2'd1;
      d.tnew_e   = lw ? 2'd2 : (r_alu || imm_wr || mf) ? 2'd1 : 2'd0;
      d.tnew_m   = lw ? 2'd1 : 2'd0;
      d.md_class = mul || dv || mf || mt;
      d.md_op    = mul || dv;
      d.md_div   = dv;
      return d;
   endfunction

   // A source conflicts when it matches a producer whose result is not ready in time
   function automatic logic src_hit(input logic rd_en, input logic [4:0] src,
                                    input logic [1:0] tuse, input logic [4:0] dst,
                                    input logic [1:0] tnew);
      return rd_en && (src != 5'd0) && (src == dst) && (tnew > tuse);
   endfunction

   dec_t dec_d, dec_e, dec_m;
   logic [CNT_W-1:0] busy_cnt;
   logic data_stall, md_stall;

   assign dec_d = decode(IR_D[31:26], IR_D[5:0], IR_D[25:21], IR_D[20:16], IR_D[15:11]);
   assign dec_e = decode(IR_E[31:26], IR_E[5:0], IR_E[25:21], IR_E[20:16], IR_E[15:11]);
   assign dec_m = decode(IR_M[31:26], IR_M[5:0], IR_M[25:21], IR_M[20:16], IR_M[15:11]);

   logic unused_ok;
   assign unused_ok = ^{IR_D, IR_E, IR_M, dec_d, dec_e, dec_m};

   assign data_stall =
      src_hit(dec_d.rd_rs, dec_d.rs, dec_d.tuse_rs, dec_e.dst, dec_e.tnew_e) ||
      src_hit(dec_d.rd_rs, dec_d.rs, dec_d.tuse_rs, dec_m.dst, dec_m.tnew_m) ||
      src_hit(dec_d.rd_rt, dec_d.rt, dec_d.tuse_rt, dec_e.dst, dec_e.tnew_e) ||
      src_hit(dec_d.rd_rt, dec_d.rt, dec_d.tuse_rt, dec_m.dst, dec_m.tnew_m);

   assign md_busy  = (busy_cnt != '0);
   assign md_start = reset && dec_e.md_op;
   assign md_stall = dec_d.md_class && (dec_e.md_op || md_busy);
   // Outputs are forced low while reset is held
   assign stall    = reset && (data_stall || md_stall);
   assign clear_E  = stall;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_cnt <= '0;
      end else if (md_start) begin
         busy_cnt <= dec_e.md_div ? DIV_LOAD : MULT_LOAD;
      end else if (busy_cnt != '0) begin
         busy_cnt <= busy_cnt - 1'b1;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
      end else if (stall) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule
